// File: rtl/kypd_matrix_scanner.sv
// kypd_matrix_scanner
//   Drives one keypad column low at a time, snapshots the active-low rows,
//   debounces every key on its own and queues debounced key events in a small
//   FIFO read out over a valid/ready handshake.
//   Optional feature: define KYPD_RELEASE_EVT_EN to queue release events too.
//   Without it, releases still update the debounced state but push nothing.
module kypd_matrix_scanner #(
  parameter  int NUM_ROWS      = 4,
  parameter  int NUM_COLS      = 4,
  parameter  int SCAN_CYCLES   = 100000,
  parameter  int SETTLE_CYCLES = 8,
  parameter  int DEBOUNCE      = 3,
  parameter  int FIFO_DEPTH    = 4,
  localparam int NUM_KEYS      = NUM_ROWS * NUM_COLS,
  localparam int CODE_W        = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] Row,
  output logic [NUM_COLS-1:0] Col,
  output logic [CODE_W-1:0]   KeyCode,
  output logic                KeyPress,
  output logic                KeyValid,
  input  logic                KeyReady,
  output logic                KeyHeld,
  output logic                Overflow,
  input  logic                OvfClr
);

  localparam int T_W   = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int C_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int R_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic              press;
    logic [CODE_W-1:0] code;
  } evt_t;

  // Column sequencer
  logic [T_W-1:0] t_q, t_d;
  logic [C_W-1:0] c_q, c_d;
  logic           t_wrap;

  // Row snapshot and per-key debounce state
  logic [NUM_ROWS-1:0] snap_q;
  logic [NUM_KEYS-1:0] deb_q, deb_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic                eval_en;
  logic [R_W-1:0]      eval_row;
  logic [CODE_W-1:0]   key_idx;
  logic                raw;

  // Debounced event and FIFO push/pop
  logic              evt_valid;
  logic              evt_press;
  logic [CODE_W-1:0] evt_code;
  logic              push, pop, do_write, full, empty, ovf_set;

  // FIFO storage and status
  evt_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             held_q;

  // Next column/cycle position of the scan
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // values computed earlier in the same pass; clocked blocks use '<=' only.
  always_comb begin
    t_wrap = (t_q == T_W'(SCAN_CYCLES - 1));
    t_d    = t_wrap ? '0 : t_q + T_W'(1);
    c_d    = c_q;
    if (t_wrap) begin
      c_d = (c_q == C_W'(NUM_COLS - 1)) ? '0 : c_q + C_W'(1);
    end
  end

  // Scan position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= '0;
      c_q <= '0;
    end else begin
      t_q <= t_d;
      c_q <= c_d;
    end
  end

  assign Col = ~(NUM_COLS'(1) << c_q);

  // Capture the inverted rows once they have settled after a column switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
    end else if (t_q == T_W'(SETTLE_CYCLES)) begin
      snap_q <= ~Row;
    end
  end

  // Select the row evaluated this cycle: one row per cycle, ascending
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    eval_en  = 1'b0;
    eval_row = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (t_q == T_W'(SETTLE_CYCLES + 1 + r)) begin
        eval_en  = 1'b1;
        eval_row = R_W'(r);
      end
    end
  end

  assign key_idx = CODE_W'(int'(eval_row) * NUM_COLS + int'(c_q));
  assign raw     = snap_q[eval_row];

  // Debounce the evaluated key and generate an event on a state change
  always_comb begin
    deb_d     = deb_q;
    cnt_d     = cnt_q;
    evt_valid = 1'b0;
    evt_press = 1'b0;
    evt_code  = key_idx;
    if (eval_en) begin
      if (raw == deb_q[key_idx]) begin
        cnt_d[key_idx] = '0;
      end else if (int'(cnt_q[key_idx]) + 1 == DEBOUNCE) begin
        deb_d[key_idx] = raw;
        cnt_d[key_idx] = '0;
        evt_valid      = 1'b1;
        evt_press      = raw;
      end else begin
        cnt_d[key_idx] = cnt_q[key_idx] + CNT_W'(1);
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  // FIFO control: push filtering, full/empty, overflow detection
  always_comb begin
`ifdef KYPD_RELEASE_EVT_EN
    push = evt_valid;
`else
    push = evt_valid & evt_press;
`endif
    full     = (occ_q == OCC_W'(FIFO_DEPTH));
    empty    = (occ_q == '0);
    pop      = !empty && KeyReady;
    do_write = push && (!full || pop);
    ovf_set  = push && full && !pop;
    occ_d    = occ_q + OCC_W'(do_write) - OCC_W'(pop);
    ovf_d    = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (OvfClr) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO pointers, occupancy, overflow flag and held indicator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q  <= occ_d;
      ovf_q  <= ovf_d;
      held_q <= |deb_q;
    end
  end

  // FIFO storage
  // NOTE: the entry array has no reset; occupancy is reset and the head is
  // masked while empty, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= '{press: evt_press, code: evt_code};
    end
  end

  // Head-of-queue outputs, forced to zero while nothing is queued
  always_comb begin
    KeyValid = !empty;
    KeyCode  = '0;
    KeyPress = 1'b0;
    if (!empty) begin
      KeyCode  = mem_q[rd_ptr_q].code;
      KeyPress = mem_q[rd_ptr_q].press;
    end
  end

  assign KeyHeld  = held_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_kypd_matrix_scanner.sv
// Self-checking bench for kypd_matrix_scanner (4x4, short scan timing).
// A frame-level key model predicts the event stream; a monitor records what
// the DUT hands out over valid/ready.
module tb_kypd_matrix_scanner;

  localparam int NR     = 4;
  localparam int NC     = 4;
  localparam int SCAN   = 16;
  localparam int SETTLE = 4;
  localparam int DEB    = 2;
  localparam int DEPTH  = 4;
  localparam int FRAME  = NC * SCAN;
`ifdef KYPD_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  typedef struct {
    int code;
    int press;
    int cyc;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_press, key_valid, key_ready, key_held, overflow, ovf_clr;
  logic [15:0] pressed;

  int   cyc;
  int   n_checks;
  int   n_fail;
  evt_t exp_q[$];
  evt_t obs_q[$];
  int   mdeb [16];
  int   mcnt [16];
  int   mocc;
  int   movf;

  kypd_matrix_scanner #(
    .NUM_ROWS     (NR),
    .NUM_COLS     (NC),
    .SCAN_CYCLES  (SCAN),
    .SETTLE_CYCLES(SETTLE),
    .DEBOUNCE     (DEB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Row     (row),
    .Col     (col),
    .KeyCode (key_code),
    .KeyPress(key_press),
    .KeyValid(key_valid),
    .KeyReady(key_ready),
    .KeyHeld (key_held),
    .Overflow(overflow),
    .OvfClr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key connects its row to its column
  always_comb begin
    row = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (!col[c] && pressed[r*NC+c]) row[r] = 1'b0;
  end

  // Record every accepted handshake, mid-cycle away from the clock edge
  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready)
      obs_q.push_back('{int'(key_code), int'(key_press), cyc});
  end

  task automatic check(input string tag, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One frame of the keypad as the spec describes it: every key sampled once,
  // columns in order, rows ascending within a column.
  task automatic model_frame(input logic [15:0] pat, input bit rdy);
    if (rdy) mocc = 0;
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < NR; r++) begin
        int k = r * NC + c;
        int rv = int'(pat[k]);
        if (rv == mdeb[k]) begin
          mcnt[k] = 0;
        end else if (mcnt[k] + 1 == DEB) begin
          mdeb[k] = rv;
          mcnt[k] = 0;
          if (rv == 1 || REL_EN) begin
            if (rdy || mocc < DEPTH) begin
              exp_q.push_back('{k, rv, 0});
              if (!rdy) mocc++;
            end else begin
              movf = 1;
            end
          end
        end else begin
          mcnt[k]++;
        end
      end
    end
  endtask

  task automatic run_frames(input logic [15:0] pat, input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      pressed   = pat;
      key_ready = rdy;
      model_frame(pat, rdy);
      repeat (FRAME) tick();
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    check($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_code%0d", tag, i), obs_q[i].code, exp_q[i].code);
      check($sformatf("%s_press%0d", tag, i), obs_q[i].press, exp_q[i].press);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic int model_held();
    for (int k = 0; k < 16; k++) if (mdeb[k] != 0) return 1;
    return 0;
  endfunction

  initial begin
    int f0;
    logic [15:0] pat;
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    mocc      = 0;
    movf      = 0;
    pressed   = '0;
    key_ready = 1'b1;
    ovf_clr   = 1'b0;
    for (int k = 0; k < 16; k++) begin
      mdeb[k] = 0;
      mcnt[k] = 0;
    end

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    // Scan sequence straight out of reset
    check("rst_held", int'(key_held), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_code", int'(key_code), 0);
    check("rst_press", int'(key_press), 0);
    for (int k = 0; k <= FRAME; k++) begin
      check($sformatf("scan_col_c%0d", k), int'(col), 15 ^ (1 << ((k / SCAN) % NC)));
      check($sformatf("scan_valid_c%0d", k), int'(key_valid), 0);
      if (k < FRAME) tick();
    end

    // Glitch: key 2 pressed during a single column-2 window
    run_frames(16'h0004, 1, 1'b1);
    check("glitch_held1", int'(key_held), 0);
    run_frames(16'h0000, 1, 1'b1);
    check("glitch_held2", int'(key_held), 0);
    compare_events("glitch");

    // Single press of key 9 (row 2, column 1)
    run_frames(16'h0200, 1, 1'b1);
    check("single_held1", int'(key_held), 0);
    f0 = cyc;
    run_frames(16'h0200, 1, 1'b1);
    check("single_held2", int'(key_held), 1);
    run_frames(16'h0200, 1, 1'b1);
    check("single_n", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      check("single_code", obs_q[0].code, 9);
      check("single_press", obs_q[0].press, 1);
      check("single_cyc", obs_q[0].cyc, f0 + SCAN + SETTLE + 1 + 2 + 1);
    end
    compare_events("single");

    // Same-column multi-key: keys 1 and 5 together with 9 held
    run_frames(16'h0222, 2, 1'b1);
    check("multi_n", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      check("multi_first", obs_q[0].code, 1);
      check("multi_second", obs_q[1].code, 5);
      check("multi_consec", obs_q[1].cyc - obs_q[0].cyc, 1);
    end
    compare_events("multi");
    run_frames(16'h0200, 2, 1'b1);
    compare_events("multi_rel");

    // Backpressure: five new keys with the consumer stalled
    pat = 16'h0200 | 16'h0001 | 16'h0040 | 16'h0400 | 16'h0008 | 16'h8000;
    run_frames(pat, 2, 1'b0);
    check("bp_ovf", int'(overflow), movf);
    check("bp_ovf_set", int'(overflow), 1);
    check("bp_valid", int'(key_valid), 1);
    check("bp_head", int'(key_code), (exp_q.size() > 0) ? exp_q[0].code : -1);
    check("bp_nobs", obs_q.size(), 0);
    run_frames(pat, 1, 1'b1);
    compare_events("drain");
    check("drain_valid", int'(key_valid), 0);
    check("drain_ovf_sticky", int'(overflow), 1);
    pressed   = pat;
    key_ready = 1'b1;
    model_frame(pat, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    movf    = 0;
    check("ovf_clr", int'(overflow), movf);
    repeat (FRAME - 1) tick();
    run_frames(16'h0200, 2, 1'b1);
    compare_events("bp_rel");

    // Randomised key patterns held for a random number of frames
    for (int i = 0; i < 10; i++) begin
      pat = 16'($urandom);
      if ($urandom_range(0, 1) == 1) pat = pat & 16'($urandom);
      run_frames(pat, $urandom_range(1, 3), 1'b1);
      compare_events($sformatf("rand%0d", i));
      check($sformatf("rand%0d_held", i), int'(key_held), model_held());
      check($sformatf("rand%0d_ovf", i), int'(overflow), 0);
    end

    // Release of key 9 alone
    run_frames(16'h0200, 2, 1'b1);
    compare_events("pre_rel");
    run_frames(16'h0000, 2, 1'b1);
    check("rel_n", obs_q.size(), REL_EN ? 1 : 0);
    if (REL_EN && obs_q.size() > 0) begin
      check("rel_code", obs_q[0].code, 9);
      check("rel_press", obs_q[0].press, 0);
    end
    compare_events("release");
    check("rel_held", int'(key_held), 0);

    // Reset mid-scan with an event queued
    run_frames(16'h0010, 1, 1'b0);
    repeat (37) tick();
    check("prerst_valid", int'(key_valid), 1);
    check("prerst_code", int'(key_code), 4);
    check("prerst_col", int'(col), 4'b1011);
    rst_n = 1'b0;
    #1;
    check("rst_col", int'(col), 4'b1110);
    check("rst_valid", int'(key_valid), 0);
    check("rst_held2", int'(key_held), 0);
    pressed   = '0;
    key_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    obs_q.delete();
    repeat (20) tick();
    check("postrst_nobs", obs_q.size(), 0);
    check("postrst_valid", int'(key_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
